// File: rtl/calc1_pkg.sv
// Shared types and constants for the Calc1 four-port arithmetic unit.
package calc1_pkg;

  localparam int NPORTS = 4;
  localparam int DW     = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SLL = 4'd5,
    CMD_SRL = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_ERR  = 2'b10,
    RESP_RSVD = 2'b11
  } resp_e;

  // Per-port capture state: waiting for a command, waiting for operand 2,
  // or holding a complete request until the arbiter grants it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_PEND = 2'd2
  } port_st_e;

  // Raw 4-bit command is kept so that undefined codes reach the ALU and
  // are reported as invalid there.
  typedef struct packed {
    logic [3:0]    cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } req_t;

endpackage

// File: rtl/calc1_alu.sv
// Shared combinational ALU: unsigned add/sub with range checking and
// logical shifts by the low five bits of operand 2.
module calc1_alu
  import calc1_pkg::*;
(
  input  logic [3:0]    cmd,
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  output logic [DW-1:0] result,
  output resp_e         resp
);

  logic [DW:0] sum;

  // Evaluate the command; anything that is not a clean result reports ERR with zero data.
  always_comb begin
    sum    = {1'b0, op1} + {1'b0, op2};
    result = '0;
    resp   = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (!sum[DW]) begin
          result = sum[DW-1:0];
          resp   = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          result = op1 - op2;
          resp   = RESP_OK;
        end
      end
      CMD_SLL: begin
        result = op1 << op2[4:0];
        resp   = RESP_OK;
      end
      CMD_SRL: begin
        result = op1 >> op2[4:0];
        resp   = RESP_OK;
      end
      default: begin
        result = '0;
        resp   = RESP_ERR;
      end
    endcase
  end

endmodule

// File: rtl/calc1_top.sv
// Calc1 top: four requester ports, each with a two-phase operand capture
// FSM, sharing one ALU through a round-robin arbiter. Pipeline:
//   E   : command + operand 1 captured
//   E+1 : operand 2 captured, request pending
//   E+2 : (earliest) grant, request moved into the issue register
//   E+3 : ALU result registered onto the granted port's outputs
// Data buses are numbered [DW-1:0] here; the requester-side [0:31]
// numbering (bit 31 = LSB) describes the same numeric value.
module calc1_top
  import calc1_pkg::*;
(
  input  logic          c_clk,
  input  logic          reset,
  input  logic [3:0]    req1_cmd_in,
  input  logic [DW-1:0] req1_data_in,
  input  logic [3:0]    req2_cmd_in,
  input  logic [DW-1:0] req2_data_in,
  input  logic [3:0]    req3_cmd_in,
  input  logic [DW-1:0] req3_data_in,
  input  logic [3:0]    req4_cmd_in,
  input  logic [DW-1:0] req4_data_in,
  output logic [1:0]    out_resp1,
  output logic [DW-1:0] out_data1,
  output logic [1:0]    out_resp2,
  output logic [DW-1:0] out_data2,
  output logic [1:0]    out_resp3,
  output logic [DW-1:0] out_data3,
  output logic [1:0]    out_resp4,
  output logic [DW-1:0] out_data4
);

  logic [3:0]    cmd_in  [NPORTS];
  logic [DW-1:0] data_in [NPORTS];

  port_st_e      st_q    [NPORTS];
  port_st_e      st_d    [NPORTS];
  req_t          req_q   [NPORTS];
  req_t          req_d   [NPORTS];

  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    cand;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;

  logic          iss_vld_q, iss_vld_d;
  logic [1:0]    iss_port_q, iss_port_d;
  req_t          iss_req_q, iss_req_d;

  logic [DW-1:0] alu_result;
  resp_e         alu_resp;

  resp_e         resp_q  [NPORTS];
  resp_e         resp_d  [NPORTS];
  logic [DW-1:0] dout_q  [NPORTS];
  logic [DW-1:0] dout_d  [NPORTS];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  // Round-robin search from the pointer; scanning downward lets the
  // pending port closest to the pointer win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (st_q[cand] == ST_PEND) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Per-port capture FSM: commands are only accepted in IDLE, so anything
  // arriving in the operand-2 cycle or while pending is dropped.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      st_d[i]  = st_q[i];
      req_d[i] = req_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (cmd_in[i] != CMD_NOP) begin
            st_d[i]      = ST_OP2;
            req_d[i].cmd = cmd_in[i];
            req_d[i].op1 = data_in[i];
          end
        end
        ST_OP2: begin
          req_d[i].op2 = data_in[i];
          st_d[i]      = ST_PEND;
        end
        ST_PEND: begin
          if (gnt_vld && (gnt_idx == 2'(i))) begin
            st_d[i] = ST_IDLE;
          end
        end
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  // Issue stage: move the granted request toward the ALU and step the pointer past it.
  always_comb begin
    iss_vld_d  = gnt_vld;
    iss_port_d = gnt_idx;
    iss_req_d  = req_q[gnt_idx];
    ptr_d      = gnt_vld ? (gnt_idx + 2'd1) : ptr_q;
  end

  calc1_alu u_alu (
    .cmd    (iss_req_q.cmd),
    .op1    (iss_req_q.op1),
    .op2    (iss_req_q.op2),
    .result (alu_result),
    .resp   (alu_resp)
  );

  // Result demux: only the issued port sees a response, for one cycle.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      resp_d[i] = RESP_NONE;
      dout_d[i] = '0;
      if (iss_vld_q && (iss_port_q == 2'(i))) begin
        resp_d[i] = alu_resp;
        dout_d[i] = alu_result;
      end
    end
  end

  // Control and output registers; reset drops pending work and rewinds the pointer to port 1.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      ptr_q     <= 2'd0;
      iss_vld_q <= 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
        st_q[i]   <= ST_IDLE;
        resp_q[i] <= RESP_NONE;
        dout_q[i] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      iss_vld_q <= iss_vld_d;
      for (int i = 0; i < NPORTS; i++) begin
        st_q[i]   <= st_d[i];
        resp_q[i] <= resp_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  // Operand and issue data registers; qualified by the control state, so no reset needed.
  always_ff @(posedge c_clk) begin
    iss_port_q <= iss_port_d;
    iss_req_q  <= iss_req_d;
    for (int i = 0; i < NPORTS; i++) begin
      req_q[i] <= req_d[i];
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = dout_q[0];
  assign out_data2 = dout_q[1];
  assign out_data3 = dout_q[2];
  assign out_data4 = dout_q[3];

endmodule

// File: tb/tb_calc1_top.sv
// Self-checking bench for calc1_top: directed vector table, multi-port
// sequences, reset corner cases, and a randomized run against a reference model.
module tb_calc1_top;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [1:0]  resp [4];
  logic [31:0] dout [4];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  r;
    logic [31:0] d;
    string       name;
  } vec_t;

  vec_t vt[10];

  always #5 c_clk = ~c_clk;

  calc1_top dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]),
    .req1_data_in (din[0]),
    .req2_cmd_in  (cmd[1]),
    .req2_data_in (din[1]),
    .req3_cmd_in  (cmd[2]),
    .req3_data_in (din[2]),
    .req4_cmd_in  (cmd[3]),
    .req4_data_in (din[3]),
    .out_resp1    (resp[0]),
    .out_data1    (dout[0]),
    .out_resp2    (resp[1]),
    .out_data2    (dout[1]),
    .out_resp3    (resp[2]),
    .out_data3    (dout[2]),
    .out_resp4    (resp[3]),
    .out_data4    (dout[3])
  );

  // Reference: unsigned arithmetic straight from the command definitions.
  function automatic void ref_calc(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, output logic [1:0] r,
                                   output logic [31:0] d);
    logic [63:0] wide;
    r = 2'b10;
    d = 32'd0;
    case (c)
      4'd1: begin
        wide = {32'd0, a} + {32'd0, b};
        if (wide <= 64'h0000_0000_FFFF_FFFF) begin r = 2'b01; d = wide[31:0]; end
      end
      4'd2: if (a >= b) begin r = 2'b01; d = a - b; end
      4'd5: begin r = 2'b01; d = a << (b % 32); end
      4'd6: begin r = 2'b01; d = a >> (b % 32); end
      default: begin r = 2'b10; d = 32'd0; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
    cyc++;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'd0;
    end
  endtask

  task automatic chk_quiet(input string nm);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_resp_p%0d", nm, p + 1), resp[p], 32'd0);
      chk($sformatf("%s_data_p%0d", nm, p + 1), dout[p], 32'd0);
    end
  endtask

  // Hold reset while throwing commands at every port; they must be ignored.
  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < 4; p++) begin
        cmd[p] = 4'($urandom_range(1, 15));
        din[p] = $urandom;
      end
      step();
      chk_quiet("in_reset");
    end
    idle_all();
    reset = 1'b1;
    step();
    step();
    chk_quiet("post_reset");
  endtask

  // One uncontended transaction with exact latency: result on E+3 only.
  task automatic run_single(input int p, input vec_t v);
    cmd[p] = v.cmd;
    din[p] = v.a;
    step();                       // edge E
    cmd[p] = 4'hF;                // ignored in the operand-2 cycle
    din[p] = v.b;
    step();                       // edge E+1
    cmd[p] = 4'd0;
    din[p] = 32'd0;
    step();                       // edge E+2
    chk({v.name, "_early"}, resp[p], 32'd0);
    step();                       // edge E+3
    chk({v.name, "_resp"}, resp[p], v.r);
    chk({v.name, "_data"}, dout[p], v.d);
    for (int q = 0; q < 4; q++) begin
      if (q != p) chk($sformatf("%s_other_p%0d", v.name, q + 1), resp[q], 32'd0);
    end
    step();                       // edge E+4
    chk({v.name, "_oneshot"}, resp[p], 32'd0);
  endtask

  // Issue then wait (bounded) for the response; checks against the model.
  task automatic run_wait(input int p, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input string nm);
    logic [1:0]  er;
    logic [31:0] ed;
    bit          got;
    ref_calc(c, a, b, er, ed);
    cmd[p] = c;
    din[p] = a;
    step();
    cmd[p] = 4'd0;
    din[p] = b;
    step();
    din[p] = 32'd0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      if (resp[p] != 2'b00) got = 1'b1;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no response, expected one within 100 cycles", nm);
    end else begin
      chk({nm, "_resp"}, resp[p], 32'd1);
      chk({nm, "_data"}, dout[p], ed);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pair_cmds [4];
    int         ph     [4];
    int         e_edge [4];
    logic [1:0] er     [4];
    logic [31:0] ed    [4];
    logic [31:0] op2s  [4];

    vt[0] = '{4'd1, 32'd5,          32'd5,  2'd1, 32'd10,         "add_5_5"};
    vt[1] = '{4'd2, 32'd5,          32'd5,  2'd1, 32'd0,          "sub_5_5"};
    vt[2] = '{4'd5, 32'd5,          32'd5,  2'd1, 32'd160,        "sll_5_5"};
    vt[3] = '{4'd6, 32'd5,          32'd5,  2'd1, 32'd0,          "srl_5_5"};
    vt[4] = '{4'd1, 32'hFFFF_FFFF,  32'd1,  2'd2, 32'd0,          "add_carry"};
    vt[5] = '{4'd2, 32'd3,          32'd5,  2'd2, 32'd0,          "sub_under"};
    vt[6] = '{4'd3, 32'd5,          32'd5,  2'd2, 32'd0,          "cmd_0011"};
    vt[7] = '{4'd1, 32'hFFFF_FFFE,  32'd1,  2'd1, 32'hFFFF_FFFF,  "add_max"};
    vt[8] = '{4'd5, 32'd1,          32'd31, 2'd1, 32'h8000_0000,  "sll_31"};
    vt[9] = '{4'd6, 32'h8000_0000,  32'd33, 2'd1, 32'h4000_0000,  "srl_mod32"};

    idle_all();
    reset = 1'b0;

    // Reset state, then the vector table on rotating ports.
    do_reset(8);
    for (int i = 0; i < 10; i++) run_single(i % 4, vt[i]);

    // Simultaneous requests straight after reset: served 1,2,3,4 on E+3..E+6.
    do_reset(2);
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1;
      din[p] = 32'(100 * (p + 1));
    end
    step();
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    step();
    idle_all();
    step();
    chk_quiet("all4_e2");
    for (int k = 0; k < 4; k++) begin
      step();
      for (int p = 0; p < 4; p++) begin
        if (p == k) begin
          chk($sformatf("all4_resp_p%0d", p + 1), resp[p], 32'd1);
          chk($sformatf("all4_data_p%0d", p + 1), dout[p], 32'(200 * (p + 1)));
        end else begin
          chk($sformatf("all4_idle_p%0d_k%0d", p + 1, k), resp[p], 32'd0);
        end
      end
    end

    // Every ordered pair of commands back-to-back on each port.
    pair_cmds[0] = 4'd1;
    pair_cmds[1] = 4'd2;
    pair_cmds[2] = 4'd5;
    pair_cmds[3] = 4'd6;
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          run_wait(p, pair_cmds[a], 32'd5, 32'd5, $sformatf("pair_p%0d_%0d%0d_a", p + 1, a, b));
          run_wait(p, pair_cmds[b], 32'd5, 32'd5, $sformatf("pair_p%0d_%0d%0d_b", p + 1, a, b));
        end
      end
    end

    // Reset with requests pending: nothing may come out afterwards.
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1;
      din[p] = 32'd7;
    end
    step();
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    step();
    idle_all();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("pend_rst");
    end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_quiet("after_rst");
    end
    run_single(0, vt[0]);

    // Randomized traffic on all ports against the reference model.
    for (int p = 0; p < 4; p++) ph[p] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 4; p++) begin
        if (resp[p] != 2'b00) begin
          if (ph[p] != 2) begin
            compared++;
            mismatched++;
            $display("FAIL rnd_spurious_p%0d: got resp %0d, expected none (edge %0d)", p + 1, resp[p], cyc);
          end else begin
            chk($sformatf("rnd_resp_p%0d", p + 1), resp[p], er[p]);
            chk($sformatf("rnd_data_p%0d", p + 1), dout[p], ed[p]);
            chk($sformatf("rnd_lat_p%0d_%0d", p + 1, cyc - e_edge[p]),
                32'((cyc - e_edge[p] >= 3) && (cyc - e_edge[p] <= 6)), 32'd1);
            ph[p] = 0;
          end
        end else if (ph[p] == 2 && (cyc - e_edge[p]) > 6) begin
          compared++;
          mismatched++;
          $display("FAIL rnd_timeout_p%0d: got no response, expected one by E+6 (edge %0d)", p + 1, cyc);
          ph[p] = 0;
        end
      end
      for (int p = 0; p < 4; p++) begin
        case (ph[p])
          1: begin
            din[p] = op2s[p];
            cmd[p] = 4'($urandom);
            ph[p]  = 2;
          end
          2: begin
            cmd[p] = (cyc + 1 == e_edge[p] + 2) ? 4'($urandom) : 4'd0;
            din[p] = $urandom;
          end
          default: begin
            if (n < 1480 && $urandom_range(0, 2) == 0) begin
              int         k;
              logic [3:0] c;
              logic [31:0] a;
              logic [31:0] b;
              k = $urandom_range(0, 4);
              c = (k == 0) ? 4'd1 : (k == 1) ? 4'd2 : (k == 2) ? 4'd5 :
                  (k == 3) ? 4'd6 : 4'($urandom_range(1, 15));
              a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
              b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
              ref_calc(c, a, b, er[p], ed[p]);
              cmd[p]    = c;
              din[p]    = a;
              op2s[p]   = b;
              e_edge[p] = cyc + 1;
              ph[p]     = 1;
            end else begin
              cmd[p] = 4'd0;
              din[p] = $urandom;
            end
          end
        endcase
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
